// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding instruction fetch with branch redirect and wrong-path discard.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_new_program_counter,
    input  logic [XLEN-1:0] new_program_counter,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] program_counter,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            fetch_fault
);
    localparam logic [2:0] BOOT = 3'd0, FETCH = 3'd1, HOLD = 3'd2, DISCARD = 3'd3, FAULT = 3'd4;

    logic [2:0] state, n_state;
    logic [XLEN-1:0] pending_pc, n_pend, n_addr, n_instr, n_pc, tgt, dest;
    logic pending_bad, n_pbad, n_req, n_valid, n_fault, bad, jump, dbad, redirect;

    assign redirect = load_new_program_counter;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt = new_program_counter;
    assign bad = |new_program_counter[1:0];
`else
    assign tgt = new_program_counter & ~XLEN'(3);
    assign bad = 1'b0;
`endif

    always_comb begin
        n_state = state;
        n_req = mem_req;
        n_addr = mem_addr;
        n_instr = instruction;
        n_pc = program_counter;
        n_valid = instr_valid;
        n_pend = pending_pc;
        n_pbad = pending_bad;
        n_fault = fetch_fault;
        jump = 1'b0;
        dest = tgt;
        dbad = bad;
        case (state)
            BOOT: begin
                jump = 1'b1;
                dest = redirect ? tgt : RESET_PC;
                dbad = redirect & bad;
            end
            FETCH: begin
                if (redirect && !mem_ack) begin
                    n_state = DISCARD;
                    n_pend = tgt;
                    n_pbad = bad;
                end else if (redirect) begin
                    jump = 1'b1;
                end else if (mem_ack) begin
                    n_instr = mem_rdata;
                    n_pc = mem_addr;
                    n_valid = 1'b1;
                    n_req = 1'b0;
                    n_state = HOLD;
                end
            end
            HOLD: begin
                jump = redirect | instr_ready;
                dest = redirect ? tgt : program_counter + XLEN'(4);
                dbad = redirect & bad;
            end
            DISCARD: begin
                if (redirect) begin
                    n_pend = tgt;
                    n_pbad = bad;
                end
                jump = mem_ack;
                dest = redirect ? tgt : pending_pc;
                dbad = redirect ? bad : pending_bad;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: jump = redirect;
`endif
            default: n_state = BOOT;
        endcase
        // a bad destination parks in FAULT with the target shown as the PC, never fetched
        if (jump) begin
            n_valid = 1'b0;
            n_state = dbad ? FAULT : FETCH;
            n_req = !dbad;
            n_addr = dbad ? mem_addr : dest;
            n_pc = dbad ? dest : program_counter;
            n_fault = dbad;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= BOOT;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            instruction <= '0;
            program_counter <= RESET_PC;
            instr_valid <= 1'b0;
            pending_pc <= RESET_PC;
            pending_bad <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state <= n_state;
            mem_req <= n_req;
            mem_addr <= n_addr;
            instruction <= n_instr;
            program_counter <= n_pc;
            instr_valid <= n_valid;
            pending_pc <= n_pend;
            pending_bad <= n_pbad;
            fetch_fault <= n_fault;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard of delivered PCs plus redirect-target table and corner sequences.
module tb_fetch_unit;
    logic clk = 1'b0, reset_n = 1'b0, load_new_program_counter = 1'b0, mem_req, mem_ack = 1'b0;
    logic instr_valid, instr_ready = 1'b0, fetch_fault;
    logic [31:0] new_program_counter = '0, mem_addr, mem_rdata = '0, instruction, program_counter;
    logic [31:0] q[$];
    logic [31:0] e, prev_addr = '0;
    logic prev_v = 1'b0, prev_req = 1'b0;
    int checks = 0, errors = 0, delivered = 0, exp_n = 0, ack_delay = 0, cnt = 0;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_fault;
    } vec_t;
    vec_t vecs[7];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_new_program_counter(load_new_program_counter), .new_program_counter(new_program_counter),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instruction(instruction), .program_counter(program_counter),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        q.push_back(a);
        exp_n++;
    endtask

    task automatic wait_dlv();
        int c = 0;
        while (delivered < exp_n && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("wait_dlv", delivered, exp_n);
    endtask

    task automatic wait_addr_change(input logic [31:0] old);
        int c = 0;
        while (mem_addr === old && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    // memory: acks ack_delay cycles after the request is seen, one word per transaction
    always @(posedge clk) begin
        #2;
        if (mem_req && cnt >= ack_delay) begin
            mem_ack = 1'b1;
            mem_rdata = word_at(mem_addr);
            cnt = 0;
        end else begin
            mem_ack = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            cnt = mem_req ? cnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n && instr_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dlv_unexpected pc got %h exp none", program_counter);
            end else begin
                e = q.pop_front();
                chk("dlv_pc", program_counter, e);
                chk("dlv_instr", instruction, word_at(e));
                delivered++;
            end
        end
        if (reset_n && prev_req && mem_req && !mem_ack) chk("addr_stable", mem_addr, prev_addr);
        prev_v = instr_valid;
        prev_req = mem_req;
        prev_addr = mem_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[2] = '{32'h0000_0104, 32'h0000_0104, 1'b0};
        vecs[5] = '{32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[1] = '{32'h0000_0102, 32'h0000_0102, 1'b1};
        vecs[3] = '{32'h8000_0003, 32'h8000_0003, 1'b1};
        vecs[4] = '{32'h8000_0001, 32'h8000_0001, 1'b1};
`else
        vecs[1] = '{32'h0000_0102, 32'h0000_0100, 1'b0};
        vecs[3] = '{32'h8000_0003, 32'h8000_0000, 1'b0};
        vecs[4] = '{32'h8000_0001, 32'h8000_0000, 1'b0};
`endif
        repeat (3) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_pc", program_counter, 0);
        chk("rst_fault", fetch_fault, 0);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        instr_ready = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("boot_req", mem_req, 1);
        chk("boot_addr", mem_addr, 0);
        wait_dlv();
        instr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", instr_valid, 1);
            chk("hold_pc", program_counter, 32'hC);
            chk("hold_instr", instruction, word_at(32'hC));
            chk("hold_req", mem_req, 0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("next_req", mem_req, 1);
        chk("next_addr", mem_addr, 32'h10);
        push(32'h10);
        wait_dlv();
        // redirect while the fetch of 0x14 is outstanding
        ack_delay = 3;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        load_new_program_counter = 1'b1;
        new_program_counter = 32'h100;
        @(negedge clk);
        load_new_program_counter = 1'b0;
        chk("disc_addr", mem_addr, 32'h14);
        chk("disc_req", mem_req, 1);
        wait_addr_change(32'h14);
        ack_delay = 0;
        chk("disc_new_addr", mem_addr, 32'h100);
        chk("disc_new_req", mem_req, 1);
        push(32'h100);
        wait_dlv();
        // redirect in HOLD with ready, then two redirects while discarding
        ack_delay = 4;
        load_new_program_counter = 1'b1;
        new_program_counter = 32'h200;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("hredir_valid", instr_valid, 0);
        chk("hredir_addr", mem_addr, 32'h200);
        chk("hredir_req", mem_req, 1);
        instr_ready = 1'b0;
        new_program_counter = 32'h300;
        @(negedge clk);
        new_program_counter = 32'h400;
        @(negedge clk);
        load_new_program_counter = 1'b0;
        chk("disc2_addr", mem_addr, 32'h200);
        wait_addr_change(32'h200);
        ack_delay = 0;
        chk("disc2_new_addr", mem_addr, 32'h400);
        push(32'h400);
        wait_dlv();
        for (int i = 0; i < 7; i++) begin
            load_new_program_counter = 1'b1;
            new_program_counter = vecs[i].target;
            @(negedge clk);
            load_new_program_counter = 1'b0;
            chk("tbl_fault", fetch_fault, vecs[i].exp_fault);
            chk("tbl_valid", instr_valid, 0);
            if (vecs[i].exp_fault) begin
                chk("tbl_f_req", mem_req, 0);
                chk("tbl_f_pc", program_counter, vecs[i].exp_addr);
            end else begin
                chk("tbl_req", mem_req, 1);
                chk("tbl_addr", mem_addr, vecs[i].exp_addr);
                push(vecs[i].exp_addr);
                wait_dlv();
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("wrap_addr", mem_addr, 32'h0);
        chk("wrap_req", mem_req, 1);
        push(32'h0);
        wait_dlv();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_req", mem_req, 0);
        chk("rst2_instr", instruction, 0);
        reset_n = 1'b1;
        load_new_program_counter = 1'b1;
        new_program_counter = 32'h500;
        @(negedge clk);
        load_new_program_counter = 1'b0;
        chk("boot_redir_addr", mem_addr, 32'h500);
        chk("boot_redir_req", mem_req, 1);
        push(32'h500);
        wait_dlv();
        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
